// File: rtl/rom_fetch_unit.sv
// Instruction fetch stage behind the boot ROM: drives the ROM address, tags each
// returned word with its fetch PC and queues it in a small circular prefetch FIFO.
module rom_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0040,
    parameter int unsigned DEPTH    = 2,
    parameter logic [15:0] STEP     = 16'd4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetch_enable,
    output logic [15:0]             rom_address,
    input  logic [31:0]             rom_data,
    input  logic                    redirect_valid,
    input  logic [15:0]             redirect_pc,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [31:0]             instr_data,
    output logic [15:0]             instr_pc,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [15:0]   fetch_pc;
    logic [31:0]   mem_data [DEPTH];
    logic [15:0]   mem_pc   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [31:0]   hold_data;
    logic [15:0]   hold_pc;
    logic          pop;
    logic          push;

    assign rom_address = fetch_pc;
    assign fifo_count  = count;
    assign instr_valid = (count != '0);

    // An empty FIFO shows the last delivered head rather than stale storage.
    assign instr_data = instr_valid ? mem_data[rd_ptr] : hold_data;
    assign instr_pc   = instr_valid ? mem_pc[rd_ptr]   : hold_pc;

    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        if (!redirect_valid) begin
            pop  = instr_valid & instr_ready;
            push = fetch_enable & ((count < FULL) | pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            hold_data <= '0;
            hold_pc   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            if (instr_valid) begin
                hold_data <= mem_data[rd_ptr];
                hold_pc   <= mem_pc[rd_ptr];
            end
        end else begin
            if (instr_valid) begin
                hold_data <= mem_data[rd_ptr];
                hold_pc   <= mem_pc[rd_ptr];
            end
            if (push) begin
                fetch_pc <= fetch_pc + STEP;
                wr_ptr   <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset; occupancy and pointers define what is live.
    always_ff @(posedge clk) begin
        if (!reset && !redirect_valid && push) begin
            mem_data[wr_ptr] <= rom_data;
            mem_pc[wr_ptr]   <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Scoreboard bench for rom_fetch_unit: directed test-plan scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_rom_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0040;
    localparam int unsigned DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_enable;
    logic [15:0] rom_address;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [15:0] instr_pc;
    logic [1:0]  fifo_count;

    int unsigned checks = 0;
    int unsigned passed = 0;

    rom_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .STEP(16'd4)) dut (
        .clk(clk), .reset(reset), .fetch_enable(fetch_enable),
        .rom_address(rom_address), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // ROM image: byte at address a is (a - 0x3F), so 0x40..0x4B hold 01..0C.
    function automatic logic [7:0] rb(input logic [15:0] a);
        logic [15:0] d;
        d = a - 16'h003F;
        return d[7:0];
    endfunction

    function automatic logic [31:0] romword(input logic [15:0] a);
        return {rb(a + 16'd3), rb(a + 16'd2), rb(a + 16'd1), rb(a)};
    endfunction

    assign rom_data = romword(rom_address);

    // Reference model state and scoreboard of words expected at the consumer.
    logic [47:0]  sb[$];
    logic [15:0]  model_pc  = RESET_PC;
    int unsigned  model_cnt = 0;
    logic [15:0]  exp_pc_now  = RESET_PC;
    int unsigned  exp_cnt_now = 0;
    bit           checking = 1'b0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One clock cycle of stimulus; the model advances by the same rules the
    // consumer observes (flush on reset/redirect, otherwise pop then push).
    task automatic step(input bit rst, input bit en, input bit rdy,
                        input bit rv, input logic [15:0] rpc);
        bit p_pop, p_push;
        @(posedge clk); #1;
        reset = rst; fetch_enable = en; instr_ready = rdy;
        redirect_valid = rv; redirect_pc = rpc;
        exp_pc_now  = model_pc;
        exp_cnt_now = model_cnt;
        if (rst) begin
            sb.delete(); model_cnt = 0; model_pc = RESET_PC;
        end else if (rv) begin
            sb.delete(); model_cnt = 0; model_pc = rpc;
        end else begin
            p_pop  = (model_cnt > 0) && rdy;
            p_push = en && ((model_cnt < DEPTH) || p_pop);
            if (p_push) begin
                sb.push_back({model_pc, romword(model_pc)});
                model_pc = model_pc + 16'd4;
            end
            model_cnt = model_cnt + (p_push ? 1 : 0) - (p_pop ? 1 : 0);
        end
    endtask

    // Monitor: compares DUT state and every consumed word away from the clock edge.
    logic [47:0] hold    = '0;
    bit          prev_rst = 1'b0;
    always @(negedge clk) begin
        if (checking) begin
            if (prev_rst) hold = '0;
            chk("rom_address", {32'h0, rom_address}, {32'h0, exp_pc_now});
            chk("fifo_count",  {46'h0, fifo_count},  48'(exp_cnt_now));
            chk("instr_valid", {47'h0, instr_valid}, {47'h0, exp_cnt_now != 0});
            if (instr_valid) begin
                if (instr_ready && !redirect_valid && !reset) begin
                    if (sb.size() == 0) chk("unexpected_word", {instr_pc, instr_data}, 48'hx);
                    else chk("delivered_word", {instr_pc, instr_data}, sb.pop_front());
                end
                hold = {instr_pc, instr_data};
            end else begin
                chk("idle_hold", {instr_pc, instr_data}, hold);
            end
        end
        prev_rst = reset;
    end

    initial begin
        reset = 1'b1; fetch_enable = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {47'h0, instr_valid}, 48'h0);
        chk("reset_count", {46'h0, fifo_count}, 48'h0);
        chk("reset_data",  {16'h0, instr_data}, 48'h0);
        chk("reset_pc",    {32'h0, instr_pc}, 48'h0);
        chk("reset_addr",  {32'h0, rom_address}, {32'h0, RESET_PC});
        checking = 1'b1;

        // Streaming from reset, then backpressure for 5 cycles and release.
        repeat (4) step(0, 1, 1, 0, '0);
        step(1, 0, 0, 0, '0);
        repeat (5) step(0, 1, 0, 0, '0);
        repeat (4) step(0, 1, 1, 0, '0);

        // Redirect while full with ready high.
        repeat (3) step(0, 1, 0, 0, '0);
        step(0, 1, 1, 1, 16'h0050);
        repeat (4) step(0, 1, 1, 0, '0);

        // Address wrap, and back-to-back redirects.
        step(0, 1, 1, 1, 16'hFFFC);
        repeat (3) step(0, 1, 1, 0, '0);
        step(0, 1, 1, 1, 16'h1000);
        step(0, 1, 1, 1, 16'h2002);
        repeat (3) step(0, 1, 1, 0, '0);

        // Fetch disabled with two entries queued, then resumed.
        repeat (3) step(0, 1, 0, 0, '0);
        repeat (4) step(0, 0, 1, 0, '0);
        repeat (3) step(0, 1, 1, 0, '0);

        // Reset mid-stream with the FIFO full.
        repeat (3) step(0, 1, 0, 0, '0);
        step(1, 1, 1, 0, '0);
        repeat (3) step(0, 1, 1, 0, '0);

        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0,
                 16'($urandom));
        end
        repeat (3) step(0, 0, 1, 0, '0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
